// File: rtl/onehot16_serial_decoder_if.sv
// Handshake bundle for onehot16_serial_decoder: lane-vector input stream and index output stream.
// err_cnt exists only when ONEHOT_ERR_CNT_EN is defined.
interface onehot16_serial_decoder_if #(
    parameter int IN_W      = 16,
    parameter int IDX_W     = 4,
    parameter int ERR_CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_vec;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             out_multi;
    logic             zero_seen;
`ifdef ONEHOT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;
`endif

`ifdef ONEHOT_ERR_CNT_EN
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_multi, zero_seen, err_cnt
    );
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_multi, zero_seen, err_cnt
    );
`else
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_last, out_multi, zero_seen
    );
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_last, out_multi, zero_seen
    );
`endif
endinterface

// File: rtl/onehot16_serial_decoder.sv
// Serializes every set bit of a 16-bit lane vector into 4-bit indices, lowest first.
// Optional feature macro ONEHOT_ERR_CNT_EN adds a saturating non-one-hot vector counter.
module onehot16_serial_decoder #(
    parameter int IN_W      = 16,
    parameter int IDX_W     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    onehot16_serial_decoder_if.slave bus
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t           r_state;
    logic [IN_W-1:0]  r_pending;
    logic [IDX_W-1:0] r_idx;
    logic             r_last;
    logic             r_multi;
    logic             r_zeroSeen;

    logic             w_inReady;
    logic             w_inXfer;
    logic             w_outXfer;
    logic             w_inZero;
    logic             w_inMulti;
    logic             w_load;
    logic [IN_W-1:0]  w_remain;
    logic             w_remMulti;

    function automatic logic [IDX_W-1:0] lowestIdx(input logic [IN_W-1:0] vec);
        logic [IDX_W-1:0] result;
        result = '0;
        for (int i = IN_W - 1; i >= 0; i--) begin
            if (vec[i]) result = IDX_W'(i);
        end
        return result;
    endfunction

    // x & (x-1) clears the lowest set bit; a nonzero result means more than one bit was set.
    assign w_inZero   = ~|bus.in_vec;
    assign w_inMulti  = |(bus.in_vec & (bus.in_vec - IN_W'(1)));
    assign w_remain   = r_pending & (r_pending - IN_W'(1));
    assign w_remMulti = |(w_remain & (w_remain - IN_W'(1)));

    assign w_inReady  = (r_state == IDLE) || ((r_state == EMIT) && r_last && bus.out_ready);
    assign w_inXfer   = bus.in_valid && w_inReady;
    assign w_outXfer  = (r_state == EMIT) && bus.out_ready;
    assign w_load     = w_inXfer && !w_inZero;

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = (r_state == EMIT);
    assign bus.out_idx   = r_idx;
    assign bus.out_last  = r_last;
    assign bus.out_multi = r_multi;
    assign bus.zero_seen = r_zeroSeen;

    // A load can only happen in IDLE or on the final beat, so it takes priority over advancing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_multi    <= 1'b0;
            r_zeroSeen <= 1'b0;
        end else begin
            r_zeroSeen <= w_inXfer && w_inZero;
            if (w_load) begin
                r_state   <= EMIT;
                r_pending <= bus.in_vec;
                r_idx     <= lowestIdx(bus.in_vec);
                r_last    <= !w_inMulti;
                r_multi   <= w_inMulti;
            end else if (w_outXfer && r_last) begin
                r_state   <= IDLE;
                r_pending <= '0;
                r_idx     <= '0;
                r_last    <= 1'b0;
                r_multi   <= 1'b0;
            end else if (w_outXfer) begin
                r_pending <= w_remain;
                r_idx     <= lowestIdx(w_remain);
                r_last    <= !w_remMulti;
            end
        end
    end

`ifdef ONEHOT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_errCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= '0;
        end else if (w_inXfer && (w_inZero || w_inMulti) && !(&r_errCnt)) begin
            r_errCnt <= r_errCnt + ERR_CNT_W'(1);
        end
    end

    assign bus.err_cnt = r_errCnt;
`endif
endmodule
